// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit: opcodes, ALU codes,
// mux selects, the state encoding and the per-cycle control word.
package mc_ctrl_pkg;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;

    localparam logic [2:0] ALU_RTYPE = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_ADD   = 3'b010;
    localparam logic [2:0] ALU_AND   = 3'b011;
    localparam logic [2:0] ALU_SLT   = 3'b100;
    localparam logic [2:0] ALU_OR    = 3'b101;

    localparam logic [1:0] SRC_RT      = 2'b00;
    localparam logic [1:0] SRC_FOUR    = 2'b01;
    localparam logic [1:0] SRC_IMM     = 2'b10;
    localparam logic [1:0] SRC_IMM_SH2 = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_ALUOUT = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd7
    } state_e;

    typedef struct packed {
        logic       pc_en;
        logic       ir_en;
        logic       iord;
        logic       regdst;
        logic       branch;
        logic       br_en;
        logic       enw;
        logic       enr;
        logic       mux1;
        logic       jump;
        logic       alusrc_a;
        logic [1:0] alusrc;
        logic [1:0] pcsrc;
        logic [2:0] aluc;
    } ctrl_t;

    // Opcodes that continue past DECODE into EXEC (J retires in DECODE).
    function automatic logic goes_to_exec(input logic [5:0] op);
        case (op)
            OP_R, OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LW, OP_SW, OP_BEQ: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Bundle between the control unit and the shared datapath: instruction/status
// inputs, datapath strobes and mux selects, and trap/retire status.
interface multicycle_control_unit_if #(
    parameter int ALUC_W = 3,
    parameter int CNT_W  = 16
);
    logic [5:0]        OpCode;
    logic              Zero;
    logic              mem_ready;
    logic              PC_En;
    logic              IR_En;
    logic              IorD;
    logic              RegDst;
    logic              Branch;
    logic              BR_En;
    logic [ALUC_W-1:0] AluC;
    logic              EnW;
    logic              EnR;
    logic              Mux1;
    logic              Jump;
    logic              ALUSrcA;
    logic [1:0]        ALUSrc;
    logic [1:0]        PCSrc;
    logic [2:0]        state_o;
    logic              illegal_op;
    logic              mem_timeout;
    logic [CNT_W-1:0]  retire_cnt;

    modport master (
        input  OpCode, Zero, mem_ready,
        output PC_En, IR_En, IorD, RegDst, Branch, BR_En, AluC, EnW, EnR, Mux1,
               Jump, ALUSrcA, ALUSrc, PCSrc, state_o, illegal_op, mem_timeout, retire_cnt
    );

    modport slave (
        output OpCode, Zero, mem_ready,
        input  PC_En, IR_En, IorD, RegDst, Branch, BR_En, AluC, EnW, EnR, Mux1,
               Jump, ALUSrcA, ALUSrc, PCSrc, state_o, illegal_op, mem_timeout, retire_cnt
    );
endinterface

// File: rtl/mc_wait_timer.sv
// Counts consecutive cycles spent waiting on mem_ready within one state and
// flags expiry once MEM_WAIT_MAX full wait cycles have elapsed (0 = never).
module mc_wait_timer #(
    parameter int MEM_WAIT_MAX = 15
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic waiting,
    output logic expired
);
    localparam int CW = (MEM_WAIT_MAX < 1) ? 1 : $clog2(MEM_WAIT_MAX + 1);
    localparam logic [CW-1:0] LIMIT = CW'(MEM_WAIT_MAX);

    logic [CW-1:0] count_q;

    assign expired = (MEM_WAIT_MAX != 0) && waiting && (count_q == LIMIT);

    // NOTE: registered state is always updated with non-blocking assignments so
    // every always_ff samples the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count_q <= '0;
        end else if (waiting && (count_q != LIMIT)) begin
            count_q <= count_q + CW'(1);
        end
    end
endmodule

// File: rtl/multicycle_control_unit.sv
// Multi-cycle MIPS control FSM: FETCH/DECODE/EXEC/MEM/WB with a memory-ready
// timeout, illegal-opcode trap and a retired-instruction counter.
module multicycle_control_unit
    import mc_ctrl_pkg::*;
#(
    parameter int ALUC_W       = 3,
    parameter int MEM_WAIT_MAX = 15,
    parameter int CNT_W        = 16
) (
    input logic                      clk,
    input logic                      rst,
    multicycle_control_unit_if.master bus
);
    if (ALUC_W < 3) begin : g_bad_aluc_w
        $error("ALUC_W must be at least 3");
    end

    state_e           state_q, state_d;
    logic [5:0]       op_q;
    logic             illegal_q, timeout_q;
    logic [CNT_W-1:0] cnt_q;
    ctrl_t            ctl;
    logic             retire, set_illegal, set_timeout;
    logic             waiting, expired;

    assign waiting = ((state_q == ST_FETCH) || (state_q == ST_MEM)) && !bus.mem_ready;

    mc_wait_timer #(.MEM_WAIT_MAX(MEM_WAIT_MAX)) u_wait_timer (
        .clk     (clk),
        .rst     (rst),
        .clear   (state_d != state_q),
        .waiting (waiting),
        .expired (expired)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_FETCH;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q <= state_d;
            if (set_illegal) illegal_q <= 1'b1;
            if (set_timeout) timeout_q <= 1'b1;
            if (retire)      cnt_q     <= cnt_q + CNT_W'(1);
        end
    end

    // NOTE: the latched opcode is only consumed after DECODE has written it, so
    // it carries no reset; adding one would only cost reset routing.
    always_ff @(posedge clk) begin
        if (state_q == ST_DECODE) op_q <= bus.OpCode;
    end

    // NOTE: every signal written here gets a default first, so no path through
    // the case statement can leave one unassigned and infer a latch.
    always_comb begin
        ctl         = '0;
        state_d     = state_q;
        retire      = 1'b0;
        set_illegal = 1'b0;
        set_timeout = 1'b0;
        if (!rst) begin
            case (state_q)
                ST_FETCH: begin
                    if (expired) begin
                        state_d     = ST_TRAP;
                        set_timeout = 1'b1;
                    end else begin
                        ctl.enr    = 1'b1;
                        ctl.alusrc = SRC_FOUR;
                        ctl.aluc   = ALU_ADD;
                        if (bus.mem_ready) begin
                            ctl.ir_en = 1'b1;
                            ctl.pc_en = 1'b1;
                            state_d   = ST_DECODE;
                        end
                    end
                end
                ST_DECODE: begin
                    ctl.alusrc = SRC_IMM_SH2;
                    ctl.aluc   = ALU_ADD;
                    if (bus.OpCode == OP_J) begin
                        ctl.jump  = 1'b1;
                        ctl.pcsrc = PC_JUMP;
                        ctl.pc_en = 1'b1;
                        state_d   = ST_FETCH;
                        retire    = 1'b1;
                    end else if (goes_to_exec(bus.OpCode)) begin
                        state_d = ST_EXEC;
                    end else begin
                        state_d     = ST_TRAP;
                        set_illegal = 1'b1;
                    end
                end
                ST_EXEC: begin
                    ctl.alusrc_a = 1'b1;
                    ctl.alusrc   = SRC_IMM;
                    state_d      = ST_WB;
                    case (op_q)
                        OP_R:    begin ctl.alusrc = SRC_RT; ctl.aluc = ALU_RTYPE; end
                        OP_ADDI: ctl.aluc = ALU_ADD;
                        OP_SLTI: ctl.aluc = ALU_SLT;
                        OP_ANDI: ctl.aluc = ALU_AND;
                        OP_ORI:  ctl.aluc = ALU_OR;
                        OP_LW, OP_SW: begin
                            ctl.aluc = ALU_ADD;
                            state_d  = ST_MEM;
                        end
                        OP_BEQ: begin
                            ctl.alusrc = SRC_RT;
                            ctl.aluc   = ALU_SUB;
                            ctl.branch = 1'b1;
                            ctl.pcsrc  = PC_ALUOUT;
                            ctl.pc_en  = bus.Zero;
                            state_d    = ST_FETCH;
                            retire     = 1'b1;
                        end
                        default: begin
                            ctl         = '0;
                            state_d     = ST_TRAP;
                            set_illegal = 1'b1;
                        end
                    endcase
                end
                ST_MEM: begin
                    if (expired) begin
                        state_d     = ST_TRAP;
                        set_timeout = 1'b1;
                    end else begin
                        ctl.iord = 1'b1;
                        ctl.enr  = (op_q == OP_LW);
                        ctl.enw  = (op_q == OP_SW);
                        if (bus.mem_ready) begin
                            state_d = (op_q == OP_SW) ? ST_FETCH : ST_WB;
                            retire  = (op_q == OP_SW);
                        end
                    end
                end
                ST_WB: begin
                    ctl.br_en  = 1'b1;
                    ctl.regdst = (op_q == OP_R);
                    ctl.mux1   = (op_q == OP_LW);
                    state_d    = ST_FETCH;
                    retire     = 1'b1;
                end
                ST_TRAP: state_d = ST_TRAP;
                default: state_d = ST_TRAP;
            endcase
        end
    end

    assign bus.PC_En       = ctl.pc_en;
    assign bus.IR_En       = ctl.ir_en;
    assign bus.IorD        = ctl.iord;
    assign bus.RegDst      = ctl.regdst;
    assign bus.Branch      = ctl.branch;
    assign bus.BR_En       = ctl.br_en;
    assign bus.AluC        = ALUC_W'(ctl.aluc);
    assign bus.EnW         = ctl.enw;
    assign bus.EnR         = ctl.enr;
    assign bus.Mux1        = ctl.mux1;
    assign bus.Jump        = ctl.jump;
    assign bus.ALUSrcA     = ctl.alusrc_a;
    assign bus.ALUSrc      = ctl.alusrc;
    assign bus.PCSrc       = ctl.pcsrc;
    assign bus.state_o     = rst ? 3'd0 : state_q;
    assign bus.illegal_op  = illegal_q & ~rst;
    assign bus.mem_timeout = timeout_q & ~rst;
    assign bus.retire_cnt  = rst ? '0 : cnt_q;
endmodule

// File: tb/tb_multicycle_control_unit.sv
// Self-checking bench: an instruction-level model builds the expected output
// vector for every cycle and a negedge process compares it against the DUT.
module tb_multicycle_control_unit;
    import mc_ctrl_pkg::*;

    localparam int ALUC_W = 4;
    localparam int MAX    = 4;
    localparam int CNT_W  = 2;

    typedef struct packed {
        logic              pc_en, ir_en, iord, regdst, branch, br_en, enw, enr, mux1, jump, alusrc_a;
        logic [1:0]        alusrc;
        logic [1:0]        pcsrc;
        logic [ALUC_W-1:0] aluc;
        logic [2:0]        state;
        logic              illegal, timeout;
        logic [CNT_W-1:0]  retire;
    } obs_t;

    logic  clk = 1'b0;
    logic  rst;
    obs_t  exp_o, act_o;
    bit    chk_en = 1'b0;
    string chk_name = "";
    int    n_checks = 0;
    int    n_pass = 0;
    int    cyc = 0;

    int retired = 0;
    bit illegal_f = 1'b0, timeout_f = 1'b0, trapped = 1'b0;

    always #5 clk = ~clk;

    multicycle_control_unit_if #(.ALUC_W(ALUC_W), .CNT_W(CNT_W)) bus ();

    multicycle_control_unit #(.ALUC_W(ALUC_W), .MEM_WAIT_MAX(MAX), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always_comb begin
        act_o          = '0;
        act_o.pc_en    = bus.PC_En;
        act_o.ir_en    = bus.IR_En;
        act_o.iord     = bus.IorD;
        act_o.regdst   = bus.RegDst;
        act_o.branch   = bus.Branch;
        act_o.br_en    = bus.BR_En;
        act_o.enw      = bus.EnW;
        act_o.enr      = bus.EnR;
        act_o.mux1     = bus.Mux1;
        act_o.jump     = bus.Jump;
        act_o.alusrc_a = bus.ALUSrcA;
        act_o.alusrc   = bus.ALUSrc;
        act_o.pcsrc    = bus.PCSrc;
        act_o.aluc     = bus.AluC;
        act_o.state    = bus.state_o;
        act_o.illegal  = bus.illegal_op;
        act_o.timeout  = bus.mem_timeout;
        act_o.retire   = bus.retire_cnt;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            n_checks++;
            if (act_o === exp_o) n_pass++;
            else $display("FAIL %s (cycle %0d): got %h expected %h", chk_name, cyc, act_o, exp_o);
        end
    end

    task automatic check(input string name, input int act, input int expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, expv);
    endtask

    function automatic bit legal(input logic [5:0] op);
        case (op)
            OP_R, OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI, OP_LW, OP_SW, OP_BEQ: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [5:0] pick_op(input int idx);
        case (idx)
            0: return OP_R;    1: return OP_ADDI; 2: return OP_SLTI; 3: return OP_ANDI;
            4: return OP_ORI;  5: return OP_LW;   6: return OP_SW;   default: return OP_BEQ;
        endcase
    endfunction

    function automatic obs_t base(input logic [2:0] st);
        obs_t e;
        e         = '0;
        e.state   = st;
        e.illegal = illegal_f;
        e.timeout = timeout_f;
        e.retire  = CNT_W'(retired % (1 << CNT_W));
        return e;
    endfunction

    task automatic noise();
        bus.OpCode    = 6'($urandom);
        bus.Zero      = 1'($urandom);
        bus.mem_ready = 1'($urandom);
    endtask

    task automatic step(input obs_t e, input string name);
        exp_o    = e;
        chk_name = name;
        chk_en   = 1'b1;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        for (int i = 0; i < n; i++) begin
            noise();
            bus.mem_ready = 1'b1;
            step('0, "reset");
        end
        rst       = 1'b0;
        retired   = 0;
        illegal_f = 1'b0;
        timeout_f = 1'b0;
        trapped   = 1'b0;
    endtask

    task automatic trap_hold(input int n);
        for (int i = 0; i < n; i++) begin
            noise();
            step(base(3'd7), "trap");
        end
    endtask

    // A FETCH or MEM access: nwait not-ready cycles then one ready cycle, unless
    // the wait limit is reached first.
    task automatic mem_phase(input logic [2:0] st, input int nwait, input logic rd,
                             input logic wr, output bit ok);
        obs_t e;
        ok = 1'b1;
        for (int i = 0; i <= nwait; i++) begin
            noise();
            bus.mem_ready = (i == nwait);
            e = base(st);
            if (MAX != 0 && i == MAX && i != nwait) begin
                step(e, "timeout_cycle");
                timeout_f = 1'b1;
                trapped   = 1'b1;
                ok        = 1'b0;
                return;
            end
            if (st == 3'd0) begin
                e.enr    = 1'b1;
                e.alusrc = 2'b01;
                e.aluc   = ALUC_W'(2);
                e.ir_en  = (i == nwait);
                e.pc_en  = (i == nwait);
                step(e, "fetch");
            end else begin
                e.iord = 1'b1;
                e.enr  = rd;
                e.enw  = wr;
                step(e, "mem");
            end
        end
    endtask

    task automatic run_instr(input logic [5:0] op, input int fw, input int mw,
                             input int zero_sel, input bit abort_in_mem);
        obs_t e;
        bit ok;
        mem_phase(3'd0, fw, 1'b0, 1'b0, ok);
        if (!ok) return;

        noise();
        bus.OpCode = op;
        e = base(3'd1);
        e.alusrc = 2'b11;
        e.aluc   = ALUC_W'(2);
        if (op == OP_J) begin
            e.jump  = 1'b1;
            e.pcsrc = 2'b10;
            e.pc_en = 1'b1;
            step(e, "decode_j");
            retired++;
            return;
        end
        step(e, "decode");
        if (!legal(op)) begin
            illegal_f = 1'b1;
            trapped   = 1'b1;
            return;
        end

        noise();
        if (zero_sel >= 0) bus.Zero = 1'(zero_sel);
        e = base(3'd2);
        e.alusrc_a = 1'b1;
        e.alusrc   = 2'b10;
        case (op)
            OP_R:    begin e.alusrc = 2'b00; e.aluc = ALUC_W'(0); end
            OP_ADDI: e.aluc = ALUC_W'(2);
            OP_SLTI: e.aluc = ALUC_W'(4);
            OP_ANDI: e.aluc = ALUC_W'(3);
            OP_ORI:  e.aluc = ALUC_W'(5);
            OP_BEQ: begin
                e.alusrc = 2'b00;
                e.aluc   = ALUC_W'(1);
                e.branch = 1'b1;
                e.pcsrc  = 2'b01;
                e.pc_en  = bus.Zero;
            end
            default: e.aluc = ALUC_W'(2);
        endcase
        step(e, "exec");
        if (op == OP_BEQ) begin
            retired++;
            return;
        end

        if (op == OP_LW || op == OP_SW) begin
            if (abort_in_mem) begin
                noise();
                bus.mem_ready = 1'b0;
                e = base(3'd3);
                e.iord = 1'b1;
                e.enr  = (op == OP_LW);
                e.enw  = (op == OP_SW);
                step(e, "mem_before_abort");
                do_reset(1);
                return;
            end
            mem_phase(3'd3, mw, op == OP_LW, op == OP_SW, ok);
            if (!ok) return;
            if (op == OP_SW) begin
                retired++;
                return;
            end
        end

        noise();
        e = base(3'd4);
        e.br_en  = 1'b1;
        e.regdst = (op == OP_R);
        e.mux1   = (op == OP_LW);
        step(e, "wb");
        retired++;
    endtask

    initial begin
        int c0;
        rst = 1'b1;
        noise();
        @(posedge clk);
        #1;
        do_reset(2);
        check("reset_state", int'(bus.state_o), 0);
        check("reset_retire", int'(bus.retire_cnt), 0);

        c0 = cyc; run_instr(OP_R, 0, 0, -1, 1'b0);
        check("r_cycles", cyc - c0, 4);
        check("r_retire", int'(bus.retire_cnt), 1);

        c0 = cyc; run_instr(OP_LW, 0, 3, -1, 1'b0);
        check("lw_cycles", cyc - c0, 8);

        c0 = cyc; run_instr(OP_BEQ, 0, 0, 1, 1'b0);
        check("beq_taken_cycles", cyc - c0, 3);
        c0 = cyc; run_instr(OP_BEQ, 0, 0, 0, 1'b0);
        check("beq_not_taken_cycles", cyc - c0, 3);
        check("retire_wrap", int'(bus.retire_cnt), 0);

        c0 = cyc; run_instr(OP_J, 0, 0, -1, 1'b0);
        check("j_cycles", cyc - c0, 2);
        check("j_back_in_fetch", int'(bus.state_o), 0);
        c0 = cyc; run_instr(OP_SW, 0, 0, -1, 1'b0);
        check("sw_cycles", cyc - c0, 4);

        run_instr(OP_ADDI, MAX, MAX, -1, 1'b0);
        check("ready_at_limit_no_timeout", int'(bus.mem_timeout), 0);

        run_instr(6'b111111, 0, 0, -1, 1'b0);
        trap_hold(3);
        check("illegal_flag", int'(bus.illegal_op), 1);
        check("illegal_state", int'(bus.state_o), 7);
        do_reset(1);
        check("illegal_cleared", int'(bus.illegal_op), 0);

        c0 = cyc; run_instr(OP_R, 10, 0, -1, 1'b0);
        check("fetch_timeout_cycles", cyc - c0, 5);
        trap_hold(2);
        check("fetch_timeout_flag", int'(bus.mem_timeout), 1);
        do_reset(1);
        check("timeout_cleared", int'(bus.mem_timeout), 0);
        check("post_reset_state", int'(bus.state_o), 0);

        run_instr(OP_LW, 0, 9, -1, 1'b0);
        trap_hold(2);
        check("mem_timeout_flag", int'(bus.mem_timeout), 1);
        do_reset(1);

        run_instr(OP_R, 0, 0, -1, 1'b0);
        run_instr(OP_SW, 1, 2, -1, 1'b1);
        check("abort_retire", int'(bus.retire_cnt), 0);

        for (int k = 0; k < 250; k++) begin
            logic [5:0] op;
            int r, fw, mw;
            r = $urandom_range(0, 19);
            if (r == 0) begin
                do op = 6'($urandom); while (legal(op) || op == OP_J);
            end else if (r == 1) begin
                op = OP_J;
            end else begin
                op = pick_op($urandom_range(0, 7));
            end
            fw = ($urandom_range(0, 15) == 0) ? MAX + 1 + $urandom_range(0, 3) : $urandom_range(0, MAX);
            mw = ($urandom_range(0, 15) == 0) ? MAX + 1 + $urandom_range(0, 3) : $urandom_range(0, MAX);
            run_instr(op, fw, mw, -1, ($urandom_range(0, 39) == 0));
            if (trapped) begin
                trap_hold(2);
                do_reset(1);
            end
        end

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
Multi-cycle successor to the single-cycle MIPS opcode decoder. It sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states and drives the datapath strobes per state rather than per opcode. It waits on a memory-ready handshake with a timeout, traps illegal opcodes, and counts retired instructions. It sits between the instruction register and the shared datapath (PC, register bank, ALU, unified memory).

Parameters:
ALUC_W, 3, width of AluC; codes are zero-extended when ALUC_W > 3, and ALUC_W < 3 is illegal.
MEM_WAIT_MAX, 15, max cycles spent waiting for mem_ready before trapping; 0 disables the timeout.
CNT_W, 16, width of retire_cnt.

Ports:
clk  in  1  clock
rst  in  1  reset
OpCode  in  6  IR[31:26]
Zero  in  1  ALU zero flag
mem_ready  in  1  memory completes current access this cycle
PC_En  out  1  PC write
IR_En  out  1  IR load
IorD  out  1  0 = PC address, 1 = ALUOut address
RegDst  out  1  1 = rd, 0 = rt
Branch  out  1  BEQ compare cycle
BR_En  out  1  register bank write
AluC  out  ALUC_W  ALU op
EnW  out  1  memory write
EnR  out  1  memory read
Mux1  out  1  1 = memory data to register bank
Jump  out  1  jump cycle
ALUSrcA  out  1  0 = PC, 1 = rs
ALUSrc  out  2  00 = rt, 01 = const 4, 10 = imm, 11 = imm<<2
PCSrc  out  2  00 = ALU, 01 = ALUOut, 10 = jump target
state_o  out  3  current state
illegal_op  out  1  sticky trap flag
mem_timeout  out  1  sticky trap flag
retire_cnt  out  CNT_W  retired instruction count

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- While rst is high and in the cycle after, state = FETCH. All outputs are 0 during reset; the flags, wait counter and retire_cnt clear to 0.
- Strobes and mux selects not listed for a state are 0.
- AluC codes: 000 = R-type (funct decoded downstream), 001 = sub, 010 = add, 011 = and, 100 = slt, 101 = or.
- FETCH
  - EnR=1, ALUSrc=01, AluC=010.
  - If mem_ready: IR_En=1, PC_En=1, go to DECODE.
  - Else stay in FETCH; the wait counter increments.
- DECODE
  - Latch OpCode internally; later states use only the latched copy.
  - ALUSrc=11, AluC=010 (branch target into ALUOut).
  - J (000010): Jump=1, PCSrc=10, PC_En=1, go to FETCH (retires).
  - R (000000), ADDI (001000), SLTI (001010), ANDI (001100), ORI (001101), LW (100011), SW (101011), BEQ (000100): go to EXEC.
  - Any other opcode: go to TRAP, set illegal_op.
- EXEC
  - ALUSrcA=1.
  - R: ALUSrc=00, AluC=000.
  - I-type: ALUSrc=10; AluC is ADDI 010, SLTI 100, ANDI 011, ORI 101.
  - LW/SW: ALUSrc=10, AluC=010.
  - BEQ: ALUSrc=00, AluC=001, Branch=1, PCSrc=01, PC_En=Zero, go to FETCH (retires).
  - LW/SW go to MEM; R/I-type go to WB.
- MEM
  - IorD=1; EnR=1 for LW, EnW=1 for SW. Held until mem_ready.
  - On ready: SW goes to FETCH (retires); LW goes to WB.
- WB
  - BR_En=1 for exactly one cycle.
  - RegDst=1 only for R; Mux1=1 only for LW.
  - Go to FETCH (retires).
- Wait counter
  - Clears on every state change.
  - In FETCH/MEM with mem_ready=0 and MEM_WAIT_MAX≠0: when the count reaches MEM_WAIT_MAX, go to TRAP and set mem_timeout. No strobe is issued that cycle.
  - If mem_ready arrives in the same cycle the limit is hit, the ready wins.
- TRAP
  - All strobes are 0; the state is absorbing until rst.
  - The flags stay high; retire_cnt freezes.
- retire_cnt increments by 1 on every retiring transition into FETCH and wraps modulo 2^CNT_W.
- rst asserted in any state (including a MEM wait) aborts the instruction: no write strobe in the reset cycle, and no increment.
- Latency (no waits): R/I/LW 4 or 5 cycles (LW = 5), SW 4, BEQ 3, J 2.
- Mealy outputs: PC_En/IR_En in FETCH (on mem_ready) and PC_En in BEQ EXEC (on Zero). Everything else is Moore.
- state_o encoding: FETCH 0, DECODE 1, EXEC 2, MEM 3, WB 4, TRAP 7.

Decomposition:
- Shared package mc_ctrl_pkg holds:
  - opcode constants;
  - AluC code constants;
  - ALUSrc/PCSrc select constants;
  - the state enum and its encoding.
- One sub-module, mc_wait_timer (parameter MEM_WAIT_MAX).
  - Inputs: clk, rst, clear, waiting.
  - Output: expired.

Test Plan:
- R-type (000000), mem_ready tied 1 → states 0,1,2,4,0. EXEC: AluC=000, ALUSrc=00. WB: BR_En=1, RegDst=1. retire_cnt=1.
- LW (100011), mem_ready low 3 cycles in MEM → EnR held 4 cycles with IorD=1. WB: Mux1=1, BR_En=1. Total 8 cycles.
- BEQ with Zero=1, then Zero=0 → PC_En=1 with PCSrc=01 on the first, PC_En=0 on the second. Both retire in 3 cycles.
- J (000010) → DECODE asserts Jump=1, PCSrc=10, PC_En=1. Back in FETCH next cycle.
- Opcode 111111 → TRAP; illegal_op=1, state_o=7, all strobes 0 until rst.
- MEM_WAIT_MAX=4 with mem_ready held 0 in FETCH → mem_timeout=1 after 4 waiting cycles. rst pulse returns state_o=0 with all flags and retire_cnt=0. Also: retire_cnt wrap with CNT_W=2 after 4 instructions → 0.
